// File: rtl/idct_pkg.sv
// idct_pkg: shared IDCT defaults, lane counts and round/saturate helpers
package idct_pkg;
   localparam int W_DEF = 16;
   localparam int OW_DEF = 17;
   localparam int NPAIR_DEF = 4;
   localparam int ROWLEN_DEF = 8;
   localparam int ROW_LANES = 8;
   localparam int COL_LANES = 8;
   // Round-half-up arithmetic right shift; a zero shift passes x through
   function automatic logic signed [63:0] round_shift(input logic signed [63:0] x, input int shift);
      return shift > 0 ? (x + (64'sd1 <<< (shift - 1))) >>> shift : x;
   endfunction
   // Rounded value clamped to the signed range of an ow-bit result
   function automatic logic signed [63:0] sat_round(input logic signed [63:0] x, input int shift, input int ow);
      logic signed [63:0] r, hi;
      r = round_shift(x, shift);
      hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
      return r > hi ? hi : r < -hi - 64'sd1 ? -hi - 64'sd1 : r;
   endfunction
   // True when sat_round would have to clamp x
   function automatic logic sat_hit(input logic signed [63:0] x, input int shift, input int ow);
      logic signed [63:0] r, hi;
      r = round_shift(x, shift);
      hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
      return r > hi || r < -hi - 64'sd1;
   endfunction
endpackage

// File: rtl/idct_bfly_lane.sv
// idct_bfly_lane: one butterfly pair, full-precision S1 then round/saturate S2
module idct_bfly_lane
   import idct_pkg::*;
#(
   parameter int W = W_DEF,
   parameter int OW = OW_DEF,
   parameter int SHIFT = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          s1_en,
   input  logic          s2_en,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   input  logic          neg,
   output logic [OW-1:0] sum,
   output logic [OW-1:0] dif,
   output logic          sat
);
   logic signed [W:0] ax, bx, s1_sum, s1_dif;
   assign ax = {a[W-1], a};
   assign bx = {b[W-1], b};
   // Saturation status of the S1 contents, consumed when they move into S2
   assign sat = sat_hit(64'(s1_sum), SHIFT, OW) || sat_hit(64'(s1_dif), SHIFT, OW);
   // S1: W+1-bit sum and difference cannot overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_sum <= '0;
         s1_dif <= '0;
      end else if (s1_en) begin
         s1_sum <= ax + bx;
         s1_dif <= neg ? bx - ax : ax - bx;
      end
   end
   // S2: rounded, shifted and clamped results
   always_ff @(posedge clk) begin
      if (rst) begin
         sum <= '0;
         dif <= '0;
      end else if (s2_en) begin
         sum <= OW'(sat_round(64'(s1_sum), SHIFT, OW));
         dif <= OW'(sat_round(64'(s1_dif), SHIFT, OW));
      end
   end
endmodule

// File: rtl/idct_bfly_stage.sv
// idct_bfly_stage: NPAIR-wide two-stage butterfly with valid/ready and row framing
module idct_bfly_stage
   import idct_pkg::*;
#(
   parameter int W = W_DEF,
   parameter int OW = OW_DEF,
   parameter int NPAIR = NPAIR_DEF,
   parameter int SHIFT = 0,
   parameter int ROWLEN = ROWLEN_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [NPAIR*W-1:0]  in_a,
   input  logic [NPAIR*W-1:0]  in_b,
   input  logic [NPAIR-1:0]    in_neg,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [NPAIR*OW-1:0] out_sum,
   output logic [NPAIR*OW-1:0] out_dif,
   output logic                out_last,
   output logic                sat_flag
);
   localparam int CW = ROWLEN > 1 ? $clog2(ROWLEN) : 1;
   logic s1_valid, s1_adv, s2_adv;
   logic [NPAIR-1:0] lane_sat;
   logic [CW-1:0] cnt;
   assign s2_adv = !out_valid || out_ready;
   assign s1_adv = !s1_valid || s2_adv;
   assign in_ready = s1_adv;
   assign out_last = out_valid && cnt == CW'(ROWLEN - 1);
   for (genvar i = 0; i < NPAIR; i++) begin : g_lane
      idct_bfly_lane #(.W(W), .OW(OW), .SHIFT(SHIFT)) u_lane (
         .clk(clk),
         .rst(rst),
         .s1_en(s1_adv && in_valid),
         .s2_en(s2_adv && s1_valid),
         .a(in_a[i*W +: W]),
         .b(in_b[i*W +: W]),
         .neg(in_neg[i]),
         .sum(out_sum[i*OW +: OW]),
         .dif(out_dif[i*OW +: OW]),
         .sat(lane_sat[i])
      );
   end
   // Pipeline occupancy, output beat counter and sticky saturation flag
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         out_valid <= 1'b0;
         cnt <= '0;
         sat_flag <= 1'b0;
      end else begin
         if (s1_adv) s1_valid <= in_valid;
         if (s2_adv) out_valid <= s1_valid;
         if (out_valid && out_ready) cnt <= cnt == CW'(ROWLEN - 1) ? '0 : cnt + 1'b1;
         if (s2_adv && s1_valid && |lane_sat) sat_flag <= 1'b1;
      end
   end
endmodule

// File: tb/tb_idct_bfly_stage.sv
// tb_idct_bfly_stage: three configurations driven in lockstep against a beat-queue model
module tb_idct_bfly_stage;
   typedef struct packed {
      logic [63:0] a;
      logic [63:0] b;
      logic [3:0]  neg;
      logic [31:0] t;
   } beat_t;
   localparam int OWS[3] = '{17, 16, 12};
   localparam int SHS[3] = '{0, 1, 0};
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic out_ready = 1'b1;
   logic [63:0] in_a = '0;
   logic [63:0] in_b = '0;
   logic [3:0] in_neg = '0;
   logic [2:0] ir, ov, ol, sf;
   logic [67:0] s0, d0;
   logic [63:0] s1, d1;
   logic [47:0] s2, d2;
   logic [127:0] osum[3], odif[3];
   beat_t q[$];
   int edge_n = 0, delivered = 0, checks = 0, errors = 0, mode = 0, stall7 = 0;
   bit sticky[3];
   bit last_acc;
   always #5 clk = ~clk;
   idct_bfly_stage #(.W(16), .OW(17), .NPAIR(4), .SHIFT(0), .ROWLEN(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_a(in_a), .in_b(in_b),
      .in_neg(in_neg), .out_valid(ov[0]), .out_ready(out_ready), .out_sum(s0), .out_dif(d0),
      .out_last(ol[0]), .sat_flag(sf[0]));
   idct_bfly_stage #(.W(16), .OW(16), .NPAIR(4), .SHIFT(1), .ROWLEN(8)) dut_r (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_a(in_a), .in_b(in_b),
      .in_neg(in_neg), .out_valid(ov[1]), .out_ready(out_ready), .out_sum(s1), .out_dif(d1),
      .out_last(ol[1]), .sat_flag(sf[1]));
   idct_bfly_stage #(.W(16), .OW(12), .NPAIR(4), .SHIFT(0), .ROWLEN(8)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_a(in_a), .in_b(in_b),
      .in_neg(in_neg), .out_valid(ov[2]), .out_ready(out_ready), .out_sum(s2), .out_dif(d2),
      .out_last(ol[2]), .sat_flag(sf[2]));
   assign osum[0] = 128'(s0);
   assign odif[0] = 128'(d0);
   assign osum[1] = 128'(s1);
   assign odif[1] = 128'(d1);
   assign osum[2] = 128'(s2);
   assign odif[2] = 128'(d2);
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // Reference: plain integer butterfly, floor-rounded division, clamp to ow bits
   function automatic logic [127:0] expv(input beat_t bt, input int c, input bit d, output bit s);
      logic [127:0] e;
      int a, b, x, r, ow, hi, p;
      e = '0;
      s = 1'b0;
      ow = OWS[c];
      hi = (1 << (ow - 1)) - 1;
      p = 1 << SHS[c];
      for (int i = 0; i < 4; i++) begin
         a = $signed(bt.a[i*16 +: 16]);
         b = $signed(bt.b[i*16 +: 16]);
         x = d ? (bt.neg[i] ? b - a : a - b) : a + b;
         x = x + p / 2;
         r = x >= 0 ? x / p : -((-x + p - 1) / p);
         if (r > hi) begin
            r = hi;
            s = 1'b1;
         end else if (r < -hi - 1) begin
            r = -hi - 1;
            s = 1'b1;
         end
         e |= (128'(r) & ((128'd1 << ow) - 128'd1)) << (i * ow);
      end
      return e;
   endfunction
   // One clock: check outputs against the model, then advance the model past the edge
   task automatic cyc();
      bit exp_ov, exp_ir, acc, pop, s_sum, s_dif;
      logic [127:0] es, ed;
      exp_ov = q.size() > 0 && int'(q[0].t) < edge_n;
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? (edge_n % 3 == 0) : mode == 3 ? 1'b0 : ($urandom_range(0, 2) != 0);
      if (mode == 2 && exp_ov && delivered == 7 && stall7 > 0) begin
         out_ready = 1'b0;
         stall7--;
      end
      @(negedge clk);
      exp_ir = !(q.size() == 2 && !out_ready);
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("in_ready[%0d]", c), 128'(ir[c]), 128'(exp_ir));
         chk($sformatf("out_valid[%0d]", c), 128'(ov[c]), 128'(exp_ov));
         if (exp_ov) begin
            es = expv(q[0], c, 1'b0, s_sum);
            ed = expv(q[0], c, 1'b1, s_dif);
            chk($sformatf("out_sum[%0d]", c), osum[c], es);
            chk($sformatf("out_dif[%0d]", c), odif[c], ed);
            chk($sformatf("out_last[%0d]", c), 128'(ol[c]), 128'(delivered == 7));
            chk($sformatf("sat_flag[%0d]", c), 128'(sf[c]), 128'(sticky[c] | s_sum | s_dif));
         end
      end
      acc = in_valid && exp_ir && !rst;
      pop = exp_ov && out_ready && !rst;
      @(posedge clk);
      edge_n++;
      if (rst) begin
         q.delete();
         delivered = 0;
         sticky = '{0, 0, 0};
      end else begin
         if (pop) begin
            for (int c = 0; c < 3; c++) begin
               es = expv(q[0], c, 1'b0, s_sum);
               ed = expv(q[0], c, 1'b1, s_dif);
               sticky[c] |= s_sum | s_dif;
            end
            void'(q.pop_front());
            delivered = (delivered + 1) % 8;
         end
         if (acc) q.push_back('{a: in_a, b: in_b, neg: in_neg, t: 32'(edge_n)});
      end
      last_acc = acc;
      #1;
   endtask
   task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [3:0] neg);
      in_a = a;
      in_b = b;
      in_neg = neg;
      in_valid = 1'b1;
      last_acc = 1'b0;
      for (int k = 0; k < 50 && !last_acc; k++) cyc();
      checks++;
      assert (last_acc) else begin
         errors++;
         $error("FAIL accept_timeout: observed no accept expected accept within 50 cycles");
      end
   endtask
   task automatic send_rand();
      logic [63:0] a, b;
      for (int i = 0; i < 4; i++) begin
         a[i*16 +: 16] = 16'($urandom);
         b[i*16 +: 16] = 16'($urandom);
      end
      send(a, b, 4'($urandom));
   endtask
   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) cyc();
   endtask
   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", 128'(ov[0]), 128'(0));
      chk("reset_in_ready", 128'(ir[0]), 128'(1));
      chk("reset_out_sum", osum[0], 128'(0));
      chk("reset_out_dif", odif[0], 128'(0));
      chk("reset_out_last", 128'(ol[0]), 128'(0));
      chk("reset_sat_flag", 128'(sf[0]), 128'(0));
      @(posedge clk);
      #1;
      mode = 0;
      send({4{16'sd100}}, {4{-16'sd30}}, 4'h0);
      idle(3);
      send({4{16'sd5}}, {4{16'sd9}}, 4'hf);
      send({4{16'sd32767}}, {4{16'sd32767}}, 4'h0);
      idle(3);
      chk("no_sat_w17", 128'(sf[0]), 128'(0));
      chk("no_sat_round", 128'(sf[1]), 128'(0));
      send({4{16'sd2047}}, {4{16'sd1}}, 4'h0);
      idle(3);
      chk("sat_sticky", 128'(sf[2]), 128'(1));
      mode = 1;
      repeat (10) send_rand();
      idle(6);
      mode = 0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      mode = 2;
      stall7 = 2;
      repeat (16) send_rand();
      idle(8);
      mode = 3;
      repeat (2) send_rand();
      in_valid = 1'b0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rst_flush", 128'(ov[0]), 128'(0));
      mode = 0;
      idle(2);
      repeat (8) send_rand();
      idle(4);
      mode = 2;
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 3) != 0) send_rand();
         else idle(1);
      end
      mode = 0;
      idle(6);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
